wb_ram_slave: RTL and testbench
===============================

// Module: wb_ram_slave
// PURPOSE
// - Wishbone responder: word-organised on-chip RAM, the target end of the CPU mem-stage bus master.
// - Accepts one request per cyc/stb strobe and applies byte-lane writes per sel.
// - Returns a full 32-bit read word; the master extracts sub-word lanes.
// - Inserts a configurable number of wait states before ack; exercises master stall paths.
// PARAMETERS
// - AWIDTH  10         RAM depth = 2**AWIDTH 32-bit words; word index = adr[AWIDTH+1:2]
// - WAIT    0          wait-state cycles between request accept and ack (0..15)
// - BASE    32'h0      region base, compared against adr[31:AWIDTH+2] when WB_RAM_ERR_EN is set
// PORTS
// - clk_i      in   1       clock, all state on rising edge
// - rst_i      in   1       asynchronous, active-high reset
// - bus        slave if_wb  Wishbone slave modport; fields used:
// -  .cyc      in   1       bus cycle active
// -  .stb      in   1       request strobe (single-cycle pulse from master, cyc held until ack)
// -  .we       in   1       1 = write, 0 = read
// -  .sel      in   4       byte lanes; sel[3] = dat[31:24] = byte address 0 (big-endian)
// -  .adr      in   32      byte address; adr[1:0] ignored
// -  .dat_m    in   32      write data (master -> slave)
// -  .dat_s    out  32      read data (slave -> master), valid only with ack
// -  .ack      out  1       one-cycle completion pulse
// -  .err      out  1       one-cycle error pulse (WB_RAM_ERR_EN only, else tied 0)
// -  .stall    out  1       high whenever a request is held (state != S_IDLE)
// BEHAVIOUR
// - Reset: ack=0, err=0, stall=0, dat_s=0, state=S_IDLE, wait counter=0; RAM contents are not reset.
// - FSM states: S_IDLE, S_WAIT, S_RESP.
// - S_IDLE: on cyc&stb, latch adr/sel/we/dat_m; go to S_WAIT if WAIT>0, else S_RESP; load counter with WAIT-1.
// - S_WAIT: decrement counter each cycle; at 0 go to S_RESP.
// - S_RESP: one cycle with ack=1 (or err=1); return to S_IDLE.
// - Read: dat_s <= ram[idx], registered into the S_RESP cycle.
// - Write: ram[idx] lane k <= dat_m lane k for each sel[k]=1, committed at the S_RESP edge; sel=0 is a no-op write that still acks.
// - Latency: accept edge -> ack high for exactly one cycle, WAIT+1 cycles later.
// - Back-to-back: a new stb is not sampled in the S_RESP cycle; it is first accepted in S_IDLE the following cycle.
// - Abort: cyc=0 in S_WAIT or S_RESP -> S_IDLE next edge, ack/err forced 0, write not committed.
// - stb while not S_IDLE: ignored (stall=1); the master holds the request.
// - Index wrap: addresses above the RAM depth alias modulo 2**AWIDTH words, unless WB_RAM_ERR_EN is set.
// - Reset mid-transaction: immediate return to S_IDLE with outputs at reset values; a pending write is dropped.
// CONFIGURATION
// - WB_RAM_ERR_EN defined:
// -   adr[31:AWIDTH+2] != BASE[31:AWIDTH+2] -> S_RESP asserts err instead of ack.
// -   No RAM write occurs; dat_s=0; timing is identical to ack.
// - WB_RAM_ERR_EN undefined:
// -   err is tied 0 and upper address bits are ignored (aliasing).
// TESTING
// - WAIT=0, write adr 0x10 sel=f dat=0xDEADBEEF, then read 0x10 -> ack 1 cycle after each accept; dat_s=0xDEADBEEF.
// - Preload 0x11223344 at 0x20; write sel=4'b0100 dat=0x00AA0000 -> read gives 0x11AA3344.
// - WAIT=3, read -> ack exactly 4 cycles after accept; stall=1 for the intervening cycles, ack width 1.
// - WAIT=3, write 0x55 to 0x30, drop cyc 2 cycles after accept -> no ack; later read of 0x30 returns the old value.
// - Assert rst_i mid-S_WAIT -> ack/stall/dat_s=0 the same cycle; next request completes normally.
// - WB_RAM_ERR_EN, AWIDTH=10, BASE=0: write to 0x0000_1000 -> err pulse, no ack; read of 0x0 unchanged.

Source files
------------

// File: rtl/wb_ram_slave_if.sv
// Wishbone bus bundle between the mem-stage master and the RAM slave.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output cyc, stb, we, sel, adr, dat_m,
        input  dat_s, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_m,
        output dat_s, ack, err, stall
    );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone word RAM slave with byte-lane writes and WAIT wait states.
// Define WB_RAM_ERR_EN to answer out-of-region addresses with err.
module wb_ram_slave #(
    parameter int          AWIDTH = 10,
    parameter int          WAIT   = 0,
    parameter logic [31:0] BASE   = 32'h0
) (
    input logic clk_i,
    input logic rst_i,
    if_wb.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT > 0 ? WAIT - 1 : 0);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AWIDTH-1:0] idx_q, idx_d, idx_rd;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic              bad_q, bad_d, bad_in, bad_rd;
    logic [31:0]       wdat_q, wdat_d;
    logic [31:0]       rdat_q, rdat_d;
    logic              in_resp, commit;
    logic [31:0]       mem [2**AWIDTH];

`ifdef WB_RAM_ERR_EN
    logic unused_bits;
    assign bad_in = bus.adr[31:AWIDTH+2] != BASE[31:AWIDTH+2];
    assign unused_bits = ^{bus.adr[1:0], BASE[AWIDTH+1:0]};
`else
    logic unused_bits;
    assign bad_in = 1'b0;
    assign unused_bits = ^{bus.adr[31:AWIDTH+2], bus.adr[1:0], BASE};
`endif

    // Read data is fetched on the edge entering S_RESP; from S_IDLE
    // that is the accept edge, so the live bus address is used.
    assign idx_rd = (state_q == S_IDLE) ? bus.adr[AWIDTH+1:2] : idx_q;
    assign bad_rd = (state_q == S_IDLE) ? bad_in : bad_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        we_d    = we_q;
        bad_d   = bad_q;
        wdat_d  = wdat_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cyc && bus.stb) begin
                    idx_d   = bus.adr[AWIDTH+1:2];
                    sel_d   = bus.sel;
                    we_d    = bus.we;
                    bad_d   = bad_in;
                    wdat_d  = bus.dat_m;
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!bus.cyc)
                    state_d = S_IDLE;
                else if (cnt_q == 4'd0)
                    state_d = S_RESP;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        rdat_d = '0;
        if (state_d == S_RESP && !bad_rd)
            rdat_d = mem[idx_rd];
    end

    assign in_resp = (state_q == S_RESP) && bus.cyc;
    assign commit  = in_resp && we_q && !bad_q;

    assign bus.ack   = in_resp && !bad_q;
    assign bus.err   = in_resp && bad_q;
    assign bus.stall = (state_q != S_IDLE);
    assign bus.dat_s = rdat_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (sel_q[k])
                    mem[idx_q][8*k +: 8] <= wdat_q[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench: a WAIT=0 and a WAIT=3 slave against a byte-level RAM model.
module tb_wb_ram_slave;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_wb w0 ();
    if_wb w3 ();

    logic [1:0]  cyc, stb, we, ack, err, stall;
    logic [3:0]  sel [2];
    logic [31:0] adr [2];
    logic [31:0] dm  [2];
    logic [31:0] ds  [2];

    assign w0.cyc = cyc[0];  assign w3.cyc = cyc[1];
    assign w0.stb = stb[0];  assign w3.stb = stb[1];
    assign w0.we  = we[0];   assign w3.we  = we[1];
    assign w0.sel = sel[0];  assign w3.sel = sel[1];
    assign w0.adr = adr[0];  assign w3.adr = adr[1];
    assign w0.dat_m = dm[0]; assign w3.dat_m = dm[1];
    assign ack[0] = w0.ack;  assign ack[1] = w3.ack;
    assign err[0] = w0.err;  assign err[1] = w3.err;
    assign stall[0] = w0.stall; assign stall[1] = w3.stall;
    assign ds[0] = w0.dat_s; assign ds[1] = w3.dat_s;

    wb_ram_slave #(.AWIDTH(10), .WAIT(0), .BASE(32'h0)) u0 (
        .clk_i(clk), .rst_i(rst), .bus(w0.slave));
    wb_ram_slave #(.AWIDTH(10), .WAIT(3), .BASE(32'h0)) u3 (
        .clk_i(clk), .rst_i(rst), .bus(w3.slave));

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mdl [2][1024];
    logic [3:0]  kn  [2][1024];

    function automatic int wait_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
`ifdef WB_RAM_ERR_EN
        return a[31:12] != 20'h0;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one request, hold cyc until one cycle after the response.
    task automatic bus_txn(input int d, input bit w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] v,
                           output bit got, output int lat, output bit ak,
                           output bit e, output logic [31:0] rd,
                           output bit st_ok, output bit pl_ok);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
        adr[d] = a; sel[d] = s; dm[d] = v;
        got = 0; lat = 0; ak = 0; e = 0; rd = '0; st_ok = 1; pl_ok = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) stb[d] = 1'b0;
            if (stall[d] !== 1'b1) st_ok = 0;
            if (ack[d] === 1'b1 || err[d] === 1'b1) begin
                got = 1; lat = k; ak = ack[d]; e = err[d]; rd = ds[d];
                break;
            end
        end
        @(negedge clk);
        if (ack[d] !== 1'b0 || err[d] !== 1'b0 || stall[d] !== 1'b0) pl_ok = 0;
        cyc[d] = 1'b0;
    endtask

    bit got, ak, e, st_ok, pl_ok;
    int lat;
    logic [31:0] rd;

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ({ack[d], err[d], stall[d]} !== 3'b000 || ds[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset d%0d: ack/err/stall=%b%b%b dat=%h want 000/0",
                         d, ack[d], err[d], stall[d], ds[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        bus_txn(0, 1, 32'h10, 4'hf, 32'hDEADBEEF, got, lat, ak, e, rd, st_ok, pl_ok);
        n_chk++;
        if (!got || !ak || lat != 1 || !pl_ok) begin
            n_fail++;
            $display("FAIL wr_lat: got=%0d ack=%0d lat=%0d pulse=%0d want 1/1/1/1",
                     got, ak, lat, pl_ok);
        end
        bus_txn(0, 0, 32'h10, 4'hf, 32'h0, got, lat, ak, e, rd, st_ok, pl_ok);
        n_chk++;
        if (!got || lat != 1 || rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_data: lat=%0d dat=%h want 1/deadbeef", lat, rd);
        end
    endtask

    task automatic test_byte_lanes;
        bus_txn(0, 1, 32'h20, 4'hf, 32'h11223344, got, lat, ak, e, rd, st_ok, pl_ok);
        bus_txn(0, 1, 32'h20, 4'b0100, 32'h00AA0000, got, lat, ak, e, rd, st_ok, pl_ok);
        bus_txn(0, 0, 32'h20, 4'hf, 32'h0, got, lat, ak, e, rd, st_ok, pl_ok);
        n_chk++;
        if (rd !== 32'h11AA3344) begin
            n_fail++;
            $display("FAIL lane_wr: got %h want 11aa3344", rd);
        end
        bus_txn(0, 1, 32'h20, 4'b0000, 32'hFFFFFFFF, got, lat, ak, e, rd, st_ok, pl_ok);
        n_chk++;
        if (!got || !ak) begin
            n_fail++;
            $display("FAIL sel0_ack: got=%0d ack=%0d want 1/1", got, ak);
        end
        bus_txn(0, 0, 32'h20, 4'hf, 32'h0, got, lat, ak, e, rd, st_ok, pl_ok);
        n_chk++;
        if (rd !== 32'h11AA3344) begin
            n_fail++;
            $display("FAIL sel0_nop: got %h want 11aa3344", rd);
        end
    endtask

    task automatic test_wait_states;
        bus_txn(1, 1, 32'h40, 4'hf, 32'hA5A5_0F0F, got, lat, ak, e, rd, st_ok, pl_ok);
        n_chk++;
        if (!got || lat != 4 || !st_ok || !pl_ok) begin
            n_fail++;
            $display("FAIL w3_wr: lat=%0d stall=%0d pulse=%0d want 4/1/1",
                     lat, st_ok, pl_ok);
        end
        bus_txn(1, 0, 32'h40, 4'hf, 32'h0, got, lat, ak, e, rd, st_ok, pl_ok);
        n_chk++;
        if (!got || lat != 4 || !st_ok || !pl_ok || rd !== 32'hA5A50F0F) begin
            n_fail++;
            $display("FAIL w3_rd: lat=%0d stall=%0d pulse=%0d dat=%h want 4/1/1/a5a50f0f",
                     lat, st_ok, pl_ok, rd);
        end
    endtask

    task automatic test_abort;
        bit seen;
        bus_txn(1, 1, 32'h30, 4'hf, 32'hCAFEF00D, got, lat, ak, e, rd, st_ok, pl_ok);
        @(negedge clk);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h30;
        sel[1] = 4'hf; dm[1] = 32'h55;
        @(negedge clk);
        stb[1] = 0;
        @(negedge clk);
        cyc[1] = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[1] !== 1'b0 || err[1] !== 1'b0) seen = 1;
        end
        n_chk++;
        if (seen || stall[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ack: ack_seen=%0d stall=%b want 0/0", seen, stall[1]);
        end
        bus_txn(1, 0, 32'h30, 4'hf, 32'h0, got, lat, ak, e, rd, st_ok, pl_ok);
        n_chk++;
        if (rd !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL abort_data: got %h want cafef00d", rd);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h10; sel[0] = 4'hf;
        @(negedge clk);
        stb[0] = 0;
        n_chk++;
        if (ack[0] !== 1'b1 || ds[0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL b2b_first: ack=%b dat=%h want 1/deadbeef", ack[0], ds[0]);
        end
        stb[0] = 1; adr[0] = 32'h20;
        @(negedge clk);
        stb[0] = 0;
        n_chk++;
        if (ack[0] !== 1'b0 || stall[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: ack=%b stall=%b want 0/0", ack[0], stall[0]);
        end
        @(negedge clk);
        n_chk++;
        if (ack[0] !== 1'b0 || stall[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_stb_ignored: ack=%b stall=%b want 0/0", ack[0], stall[0]);
        end
        stb[0] = 1;
        @(negedge clk);
        stb[0] = 0;
        n_chk++;
        if (ack[0] !== 1'b1 || ds[0] !== 32'h11AA3344) begin
            n_fail++;
            $display("FAIL b2b_second: ack=%b dat=%h want 1/11aa3344", ack[0], ds[0]);
        end
        @(negedge clk);
        cyc[0] = 0;
    endtask

    task automatic test_reset_mid;
        bus_txn(1, 1, 32'h60, 4'hf, 32'hFEEDF00D, got, lat, ak, e, rd, st_ok, pl_ok);
        @(negedge clk);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h60;
        sel[1] = 4'hf; dm[1] = 32'h12345678;
        @(negedge clk);
        stb[1] = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++;
        if (ack[1] !== 1'b0 || stall[1] !== 1'b0 || ds[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid: ack=%b stall=%b dat=%h want 0/0/0",
                     ack[1], stall[1], ds[1]);
        end
        @(negedge clk);
        rst = 1'b0; cyc[1] = 0;
        bus_txn(1, 0, 32'h60, 4'hf, 32'h0, got, lat, ak, e, rd, st_ok, pl_ok);
        n_chk++;
        if (!got || lat != 4 || rd !== 32'hFEEDF00D) begin
            n_fail++;
            $display("FAIL rst_recover: lat=%0d dat=%h want 4/feedf00d", lat, rd);
        end
    endtask

    task automatic test_region;
        logic [31:0] exp0;
        bit bad;
        bad = is_bad(32'h1000);
        bus_txn(0, 1, 32'h0, 4'hf, 32'h0BAD_F00D, got, lat, ak, e, rd, st_ok, pl_ok);
        bus_txn(0, 1, 32'h1000, 4'hf, 32'h7777_8888, got, lat, ak, e, rd, st_ok, pl_ok);
        n_chk++;
        if (!got || e !== bad || ak !== !bad || lat != 1) begin
            n_fail++;
            $display("FAIL region_resp: ack=%0d err=%0d lat=%0d want err=%0d lat=1",
                     ak, e, lat, bad);
        end
        exp0 = bad ? 32'h0BADF00D : 32'h77778888;
        bus_txn(0, 0, 32'h0, 4'hf, 32'h0, got, lat, ak, e, rd, st_ok, pl_ok);
        n_chk++;
        if (rd !== exp0) begin
            n_fail++;
            $display("FAIL region_data: got %h want %h", rd, exp0);
        end
    endtask

    task automatic test_random;
        int d, idx, hi;
        bit w, bad;
        logic [31:0] a, v, mask, expd;
        logic [3:0] s;
        for (int i = 0; i < 60; i++) begin
            d   = $urandom_range(0, 1);
            w   = 1'($urandom_range(0, 1));
            idx = $urandom_range(128, 191);
            hi  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
            a   = {hi[19:0], idx[9:0], 2'($urandom_range(0, 3))};
            s   = 4'($urandom_range(0, 15));
            v   = $urandom;
            bad = is_bad(a);
            mask = '0;
            for (int k = 0; k < 4; k++)
                if (kn[d][a[11:2]][k]) mask[8*k +: 8] = 8'hFF;
            expd = mdl[d][a[11:2]] & mask;
            bus_txn(d, w, a, s, v, got, lat, ak, e, rd, st_ok, pl_ok);
            n_chk++;
            if (!got || lat != wait_of(d) + 1 || e !== bad || ak !== !bad
                || !st_ok || !pl_ok) begin
                n_fail++;
                $display("FAIL rnd%0d_resp: lat=%0d ack=%0d err=%0d st=%0d pl=%0d want lat=%0d err=%0d",
                         i, lat, ak, e, st_ok, pl_ok, wait_of(d) + 1, bad);
            end
            if (!w && !bad && mask != 0) begin
                n_chk++;
                if ((rd & mask) !== expd) begin
                    n_fail++;
                    $display("FAIL rnd%0d_data: got %h want %h (mask %h)",
                             i, rd & mask, expd, mask);
                end
            end
            if (!w && bad) begin
                n_chk++;
                if (rd !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_errdat: got %h want 0", i, rd);
                end
            end
            if (w && !bad) begin
                for (int k = 0; k < 4; k++) begin
                    if (s[k]) begin
                        mdl[d][a[11:2]][8*k +: 8] = v[8*k +: 8];
                        kn[d][a[11:2]][k] = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        cyc = '0; stb = '0; we = '0;
        for (int d = 0; d < 2; d++) begin
            sel[d] = '0; adr[d] = '0; dm[d] = '0;
            for (int j = 0; j < 1024; j++) begin
                mdl[d][j] = '0;
                kn[d][j] = '0;
            end
        end
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_wait_states();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_region();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached, want bench completion");
        $fatal(1, "watchdog");
    end
endmodule
